// File: rtl/mult_accumulator.sv
// Accumulates signed products over a prod_last-delimited vector, rescales each sum with
// round-half-up and saturation, and queues results in a 2-entry output FIFO.
module mult_accumulator #(
  parameter int unsigned PREC  = 16,
  parameter int unsigned ACC_W = 2 * PREC + 8,
  parameter int unsigned OUT_W = 2 * PREC,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*PREC-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic [5:0]        cfg_shift,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_terms,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drop_err
);

  localparam int unsigned EntW = OUT_W + 1 + CNT_W;
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] OutMaxA = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OutMinA = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StRound} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     acc_sat_q, acc_sat_d;
  logic [5:0]               shift_q, shift_d;
  logic [EntW-1:0]          fifo0_q, fifo1_q;
  logic [1:0]               count_q;
  logic                     drop_q;

  logic                     accept, pop, push;
  logic signed [ACC_W:0]    sum_ext;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  acc_add;
  int unsigned              sh_i;
  logic [ACC_W:0]           bias;
  logic signed [ACC_W:0]    rnd_sum;
  logic                     rnd_ovf;
  logic signed [ACC_W-1:0]  rnd_lim;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         r_out;
  logic                     r_sat;
  logic [EntW-1:0]          ent_new;

  assign pop    = en && out_valid && out_ready;
  assign push   = en && (state_q == StRound);
  assign accept = en && prod_valid && prod_ready;

  // Holding back while a vector is open with one entry queued reserves the slot ROUND needs.
  assign prod_ready = (state_q != StRound) && (count_q != 2'd2) &&
                      !((count_q == 2'd1) && (state_q != StIdle) && !pop);

  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - 2 * PREC){prod[2*PREC-1]}}, prod};
    acc_ovf = sum_ext[ACC_W] != sum_ext[ACC_W-1];
    acc_add = acc_ovf ? (sum_ext[ACC_W] ? AccMin : AccMax) : sum_ext[ACC_W-1:0];
  end

  // Shifts beyond ACC_W behave identically, so clamp to keep the bias representable.
  always_comb begin
    sh_i    = (32'(shift_q) > ACC_W) ? ACC_W : 32'(shift_q);
    bias    = (sh_i == 0) ? '0 : ((ACC_W + 1)'(1) << (sh_i - 1));
    rnd_sum = {acc_q[ACC_W-1], acc_q} + $signed(bias);
    rnd_ovf = rnd_sum[ACC_W] != rnd_sum[ACC_W-1];
    rnd_lim = rnd_ovf ? AccMax : rnd_sum[ACC_W-1:0];
    shifted = rnd_lim >>> sh_i;
    r_sat   = acc_sat_q || rnd_ovf;
    if (shifted > OutMaxA) begin
      r_out = OutMaxA[OUT_W-1:0];
      r_sat = 1'b1;
    end else if (shifted < OutMinA) begin
      r_out = OutMinA[OUT_W-1:0];
      r_sat = 1'b1;
    end else begin
      r_out = shifted[OUT_W-1:0];
    end
    ent_new = {r_out, r_sat, cnt_q};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_sat_d = acc_sat_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d     = acc_add;
          cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          acc_sat_d = acc_sat_q || acc_ovf;
          if (prod_last) begin
            state_d = StRound;
            shift_d = cfg_shift;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StRound: begin
        if (en) begin
          state_d   = StIdle;
          acc_d     = '0;
          cnt_d     = '0;
          acc_sat_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_sat_q <= 1'b0;
      shift_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_sat_q <= acc_sat_d;
      shift_q   <= shift_d;
      if (en && prod_valid && !prod_ready) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo0_q <= '0;
      fifo1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) fifo0_q <= ent_new;
          else fifo1_q <= ent_new;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          fifo0_q <= fifo1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            fifo0_q <= ent_new;
          end else begin
            fifo0_q <= fifo1_q;
            fifo1_q <= ent_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = fifo0_q[EntW-1 -: OUT_W];
  assign out_sat   = fifo0_q[CNT_W];
  assign out_terms = fifo0_q[CNT_W-1:0];
  assign out_valid = count_q != 2'd0;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed-vector bench for mult_accumulator with a queue-based scoreboard and output monitor.
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] prod;
  logic        prod_valid, prod_last, prod_ready;
  logic [5:0]  cfg_shift;
  logic [31:0] out_data;
  logic        out_sat;
  logic [7:0]  out_terms;
  logic        out_valid, out_ready, drop_err;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic [7:0]  terms;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .cfg_shift  (cfg_shift),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_terms  (out_terms),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] d, input logic s, input logic [7:0] t);
    res_t r;
    r.data  = d;
    r.sat   = s;
    r.terms = t;
    exp_q.push_back(r);
  endtask

  // Drives one product for one cycle once the block can take it.
  task automatic send(input logic [31:0] p, input logic last, input logic [5:0] sh);
    int n = 0;
    while (!prod_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("send_timeout", 64'(prod_ready), 64'd1);
    prod       = p;
    prod_last  = last;
    cfg_shift  = sh;
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a result is consumed on the coming edge whenever en, out_valid and out_ready are high.
  always @(negedge clk) begin
    #2;
    if (!rst && en && out_valid && out_ready) begin
      res_t got, req;
      got.data  = out_data;
      got.sat   = out_sat;
      got.terms = out_terms;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected none", got);
      end else begin
        req = exp_q.pop_front();
        check("result", 64'(got), 64'(req));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; prod = '0; prod_valid = 1'b0; prod_last = 1'b0;
    cfg_shift = '0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_prod_ready", 64'(prod_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_out_terms", 64'(out_terms), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);

    // 3 - 5 + 7 + 10 = 15; ROUND in the cycle after the last accept, valid the cycle after.
    expect_res(32'd15, 1'b0, 8'd4);
    send(32'd3, 1'b0, 6'd0);
    send(-32'sd5, 1'b0, 6'd0);
    send(32'd7, 1'b0, 6'd0);
    send(32'd10, 1'b1, 6'd0);
    check("lat_round_valid", 64'(out_valid), 64'd0);
    check("lat_round_ready", 64'(prod_ready), 64'd0);
    step();
    check("lat_valid_rise", 64'(out_valid), 64'd1);
    drain();

    // Round-half-up: 5/2 -> 3, -5/2 -> -2.
    expect_res(32'd3, 1'b0, 8'd1);
    send(32'd5, 1'b1, 6'd1);
    expect_res(32'hFFFF_FFFE, 1'b0, 8'd1);
    send(-32'sd5, 1'b1, 6'd1);
    drain();

    // Clock enable low mid-vector: 1 + 2 + 3 = 6.
    expect_res(32'd6, 1'b0, 8'd3);
    send(32'd1, 1'b0, 6'd0);
    send(32'd2, 1'b0, 6'd0);
    en = 1'b0;
    prod = 32'd100;
    for (int i = 0; i < 5; i++) begin
      prod_valid = i[0];
      step();
    end
    prod_valid = 1'b0;
    check("en_low_drop_err", 64'(drop_err), 64'd0);
    check("en_low_no_valid", 64'(out_valid), 64'd0);
    en = 1'b1;
    send(32'd3, 1'b1, 6'd0);
    drain();

    // 300 x 0x7FFF_FFFF overflows the 40-bit accumulator and saturates the term count.
    expect_res(32'h7FFF_FFFF, 1'b1, 8'd255);
    for (int i = 0; i < 300; i++) send(32'h7FFF_FFFF, (i == 299), 6'd0);
    drain();

    // Back-pressure: two results buffered, a further product is dropped and flagged.
    out_ready = 1'b0;
    expect_res(32'd1, 1'b0, 8'd1);
    send(32'd1, 1'b1, 6'd0);
    expect_res(32'd2, 1'b0, 8'd1);
    send(32'd2, 1'b1, 6'd0);
    repeat (2) step();
    check("bp_prod_ready_low", 64'(prod_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_no_drop_yet", 64'(drop_err), 64'd0);
    prod = 32'd3; prod_last = 1'b1; prod_valid = 1'b1;
    step();
    prod_valid = 1'b0; prod_last = 1'b0;
    check("bp_drop_err", 64'(drop_err), 64'd1);
    check("bp_head_stable", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    drain();
    step();
    check("bp_fifo_empty", 64'(out_valid), 64'd0);

    // Reset mid-vector with one result pending.
    out_ready = 1'b0;
    send(32'd9, 1'b1, 6'd0);
    send(32'd1, 1'b0, 6'd0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_prod_ready", 64'(prod_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_sat", 64'(out_sat), 64'd0);
    check("mid_rst_out_terms", 64'(out_terms), 64'd0);
    check("mid_rst_drop_err", 64'(drop_err), 64'd0);
    out_ready = 1'b1;
    expect_res(32'd8, 1'b0, 8'd2);
    send(32'd4, 1'b0, 6'd0);
    send(32'd4, 1'b1, 6'd0);
    drain();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
